// File: rtl/mem_defs_pkg.sv
// Shared definitions for the memory responder: FSM state encoding,
// memory-mapped I/O register addresses and the status-bit position.
package mem_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;

  localparam int unsigned STATUS_BIT = 15;

  // Builds a status-register word with only the status bit set from flag.
  function automatic logic [15:0] status_word(input logic flag);
    logic [15:0] w;
    w = '0;
    w[STATUS_BIT] = flag;
    return w;
  endfunction

endpackage

// File: rtl/mem_ram.sv
// Synchronous single-port RAM: write and registered read share one enable.
// Contents are not reset.
module mem_ram #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] r_q;

  // Single access port: commit write and capture read word on enabled edges.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end
      r_q <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/mem_responder.sv
// LC-3 memory-side responder: latches a MAR/MDR request, waits WAIT_CYCLES
// states, accesses the internal RAM and pulses ready for one cycle.
// Define MEM_MMIO_EN to decode the keyboard/display registers at 0xFE00-0xFE06.
module mem_responder
  import mem_defs::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memEN,
  input  logic              memWE,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  input  logic [7:0]        kbd_data,
  input  logic              kbd_strobe,
  output logic [7:0]        dsp_data,
  output logic              dsp_valid,
  input  logic              dsp_ready
);

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_ready;
  logic                r_rd_ram;
  logic                w_hit;
  logic                w_ram_en;
  logic [DATA_W-1:0]   w_ram_q;

  // Next-state decode; request inputs only matter in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (memEN) w_next = (WAIT_CYCLES == 0) ? ST_ACC : ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd1) w_next = ST_ACC;
      ST_ACC:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State register, request latches, wait counter and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_ready  <= 1'b0;
      r_rd_ram <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == ST_DONE);
      if (r_state == ST_IDLE && memEN) begin
        r_addr  <= addr;
        r_we    <= memWE;
        r_wdata <= wdata;
        r_cnt   <= 4'(WAIT_CYCLES);
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == ST_ACC) begin
        r_rd_ram <= !r_we && !w_hit;
      end
    end
  end

  assign w_ram_en = (r_state == ST_ACC) && !w_hit;
  assign busy     = (r_state != ST_IDLE);
  assign ready    = r_ready;

  mem_ram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (r_we),
    .i_addr  (r_addr[DEPTH_LOG2-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_q)
  );

`ifdef MEM_MMIO_EN
  logic              w_is_kbsr;
  logic              w_is_kbdr;
  logic              w_is_dsr;
  logic              w_is_ddr;
  logic              w_kbd_clr;
  logic [DATA_W-1:0] w_mmio_q;
  logic [DATA_W-1:0] r_mmio_q;
  logic              r_kbd_full;
  logic [7:0]        r_kbd_buf;
  logic [7:0]        r_dsp_data;
  logic              r_dsp_valid;

  assign w_is_kbsr = (r_addr == ADDR_W'(ADDR_KBSR));
  assign w_is_kbdr = (r_addr == ADDR_W'(ADDR_KBDR));
  assign w_is_dsr  = (r_addr == ADDR_W'(ADDR_DSR));
  assign w_is_ddr  = (r_addr == ADDR_W'(ADDR_DDR));
  assign w_hit     = w_is_kbsr || w_is_kbdr || w_is_dsr || w_is_ddr;
  assign w_kbd_clr = (r_state == ST_ACC) && !r_we && w_is_kbdr;

  // MMIO read mux; writes to the status/data registers return 0.
  always_comb begin
    w_mmio_q = '0;
    if (!r_we) begin
      if (w_is_kbsr)      w_mmio_q = DATA_W'(status_word(r_kbd_full));
      else if (w_is_kbdr) w_mmio_q = DATA_W'({8'h00, r_kbd_buf});
      else if (w_is_dsr)  w_mmio_q = DATA_W'(status_word(dsp_ready));
    end
  end

  // Capture MMIO read data on the same edge the RAM read would register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mmio_q <= '0;
    else if (r_state == ST_ACC) r_mmio_q <= w_mmio_q;
  end

  // Keyboard buffer: a strobe coinciding with a KBDR-read clear wins and
  // keeps the flag set, otherwise strobes while full are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kbd_full <= 1'b0;
      r_kbd_buf  <= '0;
    end else if (kbd_strobe && (!r_kbd_full || w_kbd_clr)) begin
      r_kbd_full <= 1'b1;
      r_kbd_buf  <= kbd_data;
    end else if (w_kbd_clr) begin
      r_kbd_full <= 1'b0;
    end
  end

  // Display write: data held, valid pulses in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dsp_data  <= '0;
      r_dsp_valid <= 1'b0;
    end else begin
      r_dsp_valid <= (r_state == ST_ACC) && r_we && w_is_ddr;
      if ((r_state == ST_ACC) && r_we && w_is_ddr) begin
        r_dsp_data <= r_wdata[7:0];
      end
    end
  end

  assign dsp_data  = r_dsp_data;
  assign dsp_valid = r_dsp_valid;
  assign rdata     = !r_ready ? '0 : (r_rd_ram ? w_ram_q : r_mmio_q);
`else
  logic w_unused;

  assign w_hit     = 1'b0;
  assign dsp_data  = '0;
  assign dsp_valid = 1'b0;
  assign rdata     = (r_ready && r_rd_ram) ? w_ram_q : '0;
  assign w_unused  = ^{kbd_data, kbd_strobe, dsp_ready, r_addr};
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: dut_a (WAIT_CYCLES=2) and dut_b
// (WAIT_CYCLES=0) share the clock and reset; read data is checked by
// per-instance scoreboards popped whenever ready is seen.
module tb_mem_responder;

  logic        clk;
  logic        rst_n;

  logic        enA, weA;
  logic [15:0] addrA, wdA, rdA;
  logic        rdyA, busyA;
  logic [7:0]  kbd_data;
  logic        kbd_strobe;
  logic [7:0]  dsp_data;
  logic        dsp_valid;
  logic        dsp_ready;

  logic        enB, weB;
  logic [15:0] addrB, wdB, rdB;
  logic        rdyB, busyB;
  logic [7:0]  dsp_dataB;
  logic        dsp_validB;

  int          cyc;
  int          tA0, tB0;
  int          n_tests;
  int          n_fail;
  logic [15:0] sbA[$];
  logic [15:0] sbB[$];

  mem_responder #(
    .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(8), .WAIT_CYCLES(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .memEN(enA), .memWE(weA), .addr(addrA),
    .wdata(wdA), .rdata(rdA), .ready(rdyA), .busy(busyA),
    .kbd_data(kbd_data), .kbd_strobe(kbd_strobe), .dsp_data(dsp_data),
    .dsp_valid(dsp_valid), .dsp_ready(dsp_ready)
  );

  mem_responder #(
    .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(8), .WAIT_CYCLES(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .memEN(enB), .memWE(weB), .addr(addrB),
    .wdata(wdB), .rdata(rdB), .ready(rdyB), .busy(busyB),
    .kbd_data(8'h00), .kbd_strobe(1'b0), .dsp_data(dsp_dataB),
    .dsp_valid(dsp_validB), .dsp_ready(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitors: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rdyA) begin
      n_tests++;
      if (sbA.size() == 0) begin
        n_fail++;
        $display("FAIL a_unexpected_ready rdata=%h expected no ready", rdA);
      end else begin
        logic [15:0] e;
        e = sbA.pop_front();
        if (rdA !== e) begin
          n_fail++;
          $display("FAIL a_rdata got=%h exp=%h", rdA, e);
        end
      end
    end
    if (rst_n && rdyB) begin
      n_tests++;
      if (sbB.size() == 0) begin
        n_fail++;
        $display("FAIL b_unexpected_ready rdata=%h expected no ready", rdB);
      end else begin
        logic [15:0] e;
        e = sbB.pop_front();
        if (rdB !== e) begin
          n_fail++;
          $display("FAIL b_rdata got=%h exp=%h", rdB, e);
        end
      end
    end
  end

  task automatic issue_a(input logic we, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] exp);
    @(negedge clk);
    enA = 1'b1; weA = we; addrA = a; wdA = d;
    sbA.push_back(exp);
    tA0 = cyc + 1;
  endtask

  task automatic issue_b(input logic we, input logic [15:0] a, input logic [15:0] d,
                         input logic [15:0] exp);
    @(negedge clk);
    enB = 1'b1; weB = we; addrB = a; wdB = d;
    sbB.push_back(exp);
    tB0 = cyc + 1;
  endtask

  // Waits (bounded) for ready; lat = edges from request sample, -1 on timeout.
  task automatic wait_a(output int lat);
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rdyA) begin lat = cyc - tA0; break; end
    end
  endtask

  task automatic wait_b(output int lat);
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rdyB) begin lat = cyc - tB0; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({rdA, rdyA, busyA, dsp_data, dsp_valid} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_a rdata=%h ready=%b busy=%b dsp=%h/%b exp all 0",
               rdA, rdyA, busyA, dsp_data, dsp_valid);
    end
    n_tests++;
    if ({rdB, rdyB, busyB} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_b rdata=%h ready=%b busy=%b exp all 0", rdB, rdyB, busyB);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    int lat;
    issue_a(1'b1, 16'h0010, 16'h1234, 16'h0000);
    @(negedge clk);
    n_tests++;
    if (busyA !== 1'b1) begin n_fail++; $display("FAIL wr_busy got=%b exp=1", busyA); end
    wait_a(lat);
    enA = 1'b0;
    n_tests++;
    if (lat != 3) begin n_fail++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    @(negedge clk);
    n_tests++;
    if (rdyA !== 1'b0) begin n_fail++; $display("FAIL wr_ready_pulse got=%b exp=0", rdyA); end
    issue_a(1'b0, 16'h0010, 16'h0000, 16'h1234);
    wait_a(lat);
    enA = 1'b0;
    n_tests++;
    if (lat != 3) begin n_fail++; $display("FAIL rd_latency got=%0d exp=3", lat); end
  endtask

  task automatic test_hold_and_perturb;
    int lat;
    issue_a(1'b1, 16'h0030, 16'h0303, 16'h0000);
    wait_a(lat); enA = 1'b0;
    issue_a(1'b1, 16'h0020, 16'hAAAA, 16'h0000);
    @(negedge clk);
    addrA = 16'h0030; wdA = 16'h5555; weA = 1'b0;
    wait_a(lat);
    n_tests++;
    if (lat != 3) begin n_fail++; $display("FAIL perturb_latency got=%0d exp=3", lat); end
    @(negedge clk);
    enA = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++;
    if (busyA !== 1'b0) begin n_fail++; $display("FAIL hold_reservice busy=%b exp=0", busyA); end
    issue_a(1'b0, 16'h0020, 16'h0000, 16'hAAAA);
    wait_a(lat); enA = 1'b0;
    issue_a(1'b0, 16'h0030, 16'h0000, 16'h0303);
    wait_a(lat); enA = 1'b0;
  endtask

  task automatic test_alias;
    int lat;
    issue_a(1'b1, 16'h0105, 16'hBEEF, 16'h0000);
    wait_a(lat); enA = 1'b0;
    issue_a(1'b0, 16'h0005, 16'h0000, 16'hBEEF);
    wait_a(lat); enA = 1'b0;
    n_tests++;
    if (lat != 3) begin n_fail++; $display("FAIL alias_latency got=%0d exp=3", lat); end
  endtask

  task automatic test_back_to_back;
    int lat;
    int t_first;
    issue_a(1'b1, 16'h0050, 16'h0A0A, 16'h0000);
    wait_a(lat);
    t_first = cyc;
    weA = 1'b0; addrA = 16'h0050; wdA = 16'h0000;
    sbA.push_back(16'h0A0A);
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rdyA) begin lat = cyc - t_first; break; end
    end
    enA = 1'b0;
    n_tests++;
    if (lat != 5) begin n_fail++; $display("FAIL b2b_period got=%0d exp=5", lat); end
  endtask

  task automatic test_reset_mid;
    int lat;
    issue_a(1'b1, 16'h0060, 16'h6666, 16'h0000);
    wait_a(lat); enA = 1'b0;
    issue_a(1'b1, 16'h0060, 16'h9999, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (busyA !== 1'b0 || rdyA !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid busy=%b ready=%b exp 0/0", busyA, rdyA);
    end
    sbA.delete();
    enA = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue_a(1'b0, 16'h0060, 16'h0000, 16'h6666);
    wait_a(lat); enA = 1'b0;
  endtask

  task automatic test_wait0;
    int lat;
    issue_b(1'b1, 16'h0007, 16'h7777, 16'h0000);
    wait_b(lat); enB = 1'b0;
    n_tests++;
    if (lat != 1) begin n_fail++; $display("FAIL w0_wr_latency got=%0d exp=1", lat); end
    issue_b(1'b0, 16'h0007, 16'h0000, 16'h7777);
    wait_b(lat); enB = 1'b0;
    n_tests++;
    if (lat != 1) begin n_fail++; $display("FAIL w0_rd_latency got=%0d exp=1", lat); end
  endtask

  task automatic strobe(input logic [7:0] c);
    @(negedge clk);
    kbd_data = c; kbd_strobe = 1'b1;
    @(negedge clk);
    kbd_strobe = 1'b0;
  endtask

`ifdef MEM_MMIO_EN
  task automatic test_mmio_kbd;
    int lat;
    strobe(8'h41);
    issue_a(1'b0, 16'hFE00, 16'h0000, 16'h8000); wait_a(lat); enA = 1'b0;
    issue_a(1'b0, 16'hFE02, 16'h0000, 16'h0041); wait_a(lat); enA = 1'b0;
    issue_a(1'b0, 16'hFE00, 16'h0000, 16'h0000); wait_a(lat); enA = 1'b0;
    strobe(8'h41);
    strobe(8'h42);
    issue_a(1'b0, 16'hFE02, 16'h0000, 16'h0041); wait_a(lat); enA = 1'b0;
    issue_a(1'b0, 16'hFE00, 16'h0000, 16'h0000); wait_a(lat); enA = 1'b0;
  endtask

  task automatic test_mmio_dsp;
    int lat;
    dsp_ready = 1'b1;
    issue_a(1'b1, 16'h0006, 16'h0606, 16'h0000); wait_a(lat); enA = 1'b0;
    issue_a(1'b0, 16'hFE04, 16'h0000, 16'h8000); wait_a(lat); enA = 1'b0;
    issue_a(1'b1, 16'hFE06, 16'h0058, 16'h0000); wait_a(lat); enA = 1'b0;
    n_tests++;
    if (dsp_valid !== 1'b1 || dsp_data !== 8'h58) begin
      n_fail++;
      $display("FAIL dsp_write valid=%b data=%h exp 1/58", dsp_valid, dsp_data);
    end
    @(negedge clk);
    n_tests++;
    if (dsp_valid !== 1'b0) begin n_fail++; $display("FAIL dsp_pulse got=%b exp=0", dsp_valid); end
    issue_a(1'b0, 16'h0006, 16'h0000, 16'h0606); wait_a(lat); enA = 1'b0;
  endtask
`else
  task automatic test_mmio_kbd;
    int lat;
    issue_a(1'b1, 16'h0000, 16'h0F0F, 16'h0000); wait_a(lat); enA = 1'b0;
    strobe(8'h41);
    issue_a(1'b0, 16'hFE00, 16'h0000, 16'h0F0F); wait_a(lat); enA = 1'b0;
  endtask

  task automatic test_mmio_dsp;
    int lat;
    dsp_ready = 1'b1;
    issue_a(1'b1, 16'hFE06, 16'h0058, 16'h0000); wait_a(lat); enA = 1'b0;
    n_tests++;
    if (dsp_valid !== 1'b0 || dsp_data !== 8'h00) begin
      n_fail++;
      $display("FAIL dsp_tied valid=%b data=%h exp 0/00", dsp_valid, dsp_data);
    end
    issue_a(1'b0, 16'h0006, 16'h0000, 16'h0058); wait_a(lat); enA = 1'b0;
  endtask
`endif

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    enA = 1'b0; weA = 1'b0; addrA = '0; wdA = '0;
    enB = 1'b0; weB = 1'b0; addrB = '0; wdB = '0;
    kbd_data = '0; kbd_strobe = 1'b0; dsp_ready = 1'b0;
    rst_n = 1'b0;
    test_reset;
    test_write_read;
    test_hold_and_perturb;
    test_alias;
    test_back_to_back;
    test_reset_mid;
    test_wait0;
    test_mmio_kbd;
    test_mmio_dsp;
    repeat (4) @(negedge clk);
    n_tests++;
    if (sbA.size() != 0 || sbB.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain pendingA=%0d pendingB=%0d exp 0/0", sbA.size(), sbB.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
